// File: rtl/twiddle_mult_sched.sv
// twiddle_mult_sched: per-stage scheduler for the shared FFT complex multiplier.
// Ports: start/stage/busy/done control; in_* sample input (valid/ready);
// mult_x/tw_addr/mult_issue to the multiplier, mult_result back after MULT_LAT;
// out_* rounded 16+16 results from a credit-limited FIFO (valid/ready, last).
module twiddle_mult_sched #(
  parameter int MULT_LAT   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int N_BFLY     = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  stage,
  output logic        busy,
  output logic        done,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [31:0] mult_x,
  output logic [4:0]  tw_addr,
  output logic        mult_issue,
  input  logic [63:0] mult_result,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  input  logic        out_ready
);

  localparam int CW = $clog2(N_BFLY + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(MULT_LAT + 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  state_t        state;
  logic [2:0]    s;
  logic [CW-1:0] b;
  logic [CW-1:0] cap_cnt;
  logic [CW-1:0] pop_cnt;
  logic [FW-1:0] credit;
  logic [FW-1:0] count;
  logic [IW-1:0] inflight;
  logic [MULT_LAT-1:0] vpipe;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [32:0]   mem [FIFO_DEPTH];

  logic       acc;
  logic       push;
  logic       pop;
  logic       start_ok;
  logic       last_pop;
  logic [4:0] tw_next;

  // Round-half-up by 2^15, then clamp to the signed 16-bit range.
  function automatic logic [15:0] rnd(input logic [31:0] x);
    logic signed [32:0] t;
    logic signed [17:0] y;
    t = $signed({x[31], x}) + 33'sd16384;
    y = t[32:15];
    if (y > 18'sd32767)
      return 16'h7fff;
    else if (y < -18'sd32768)
      return 16'h8000;
    else
      return y[15:0];
  endfunction

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits cover both the FIFO and the multiplier pipe, so a
  // sample is only taken when its product is guaranteed a slot.
  assign in_ready  = (state == RUN) && (b < CW'(N_BFLY))
                   && (credit != '0);
  assign acc       = in_valid && in_ready;
  assign push      = vpipe[MULT_LAT-1];
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr][31:0];
  assign out_last  = mem[rd_ptr][32];
  assign start_ok  = (state == IDLE) && start
                   && (stage <= 3'd5);

  // Final pop of the stage: everything else is already drained.
  assign last_pop  = pop && (pop_cnt == CW'(N_BFLY - 1))
                   && (inflight == '0) && !push
                   && (count == FW'(1));

  // Twiddle exponent: butterfly index modulo the group size,
  // scaled by 2^stage.
  always_comb begin
    logic [31:0] bx;
    logic [31:0] mask;
    bx      = 32'(b);
    mask    = (32'd32 >> s) - 32'd1;
    tw_next = 5'((bx & mask) << s);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      b     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            s     <= stage;
            b     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (acc) begin
            b <= b + 1'b1;
            if (b == CW'(N_BFLY - 1))
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_pop) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mult_issue <= 1'b0;
      mult_x     <= '0;
      tw_addr    <= '0;
      vpipe      <= '0;
      inflight   <= '0;
      credit     <= FW'(FIFO_DEPTH);
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cap_cnt    <= '0;
      pop_cnt    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      mult_issue <= acc;
      if (acc) begin
        mult_x  <= in_data;
        tw_addr <= tw_next;
      end
      vpipe[0] <= mult_issue;
      for (int i = 1; i < MULT_LAT; i++)
        vpipe[i] <= vpipe[i-1];
      inflight <= inflight + IW'(mult_issue)
                - IW'(push);
      credit   <= credit - FW'(acc) + FW'(pop);
      count    <= count + FW'(push) - FW'(pop);
      if (push) begin
        mem[wr_ptr] <= {
          cap_cnt == CW'(N_BFLY - 1),
          rnd(mult_result[63:32]),
          rnd(mult_result[31:0])
        };
        wr_ptr  <= nxt(wr_ptr);
        cap_cnt <= cap_cnt + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= nxt(rd_ptr);
        pop_cnt <= pop_cnt + 1'b1;
      end
      if (start_ok) begin
        cap_cnt <= '0;
        pop_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_mult_sched.sv
// tb_twiddle_mult_sched: directed + random stages against a queue-based
// model of twiddle addressing, rounding/saturation and output timing.
module tb_twiddle_mult_sched;

  localparam int ML = 2;
  localparam int FD = 4;
  localparam int N  = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  stage;
  logic        busy;
  logic        done;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [31:0] mult_x;
  logic [4:0]  tw_addr;
  logic        mult_issue;
  logic [63:0] mult_result;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;

  twiddle_mult_sched #(
    .MULT_LAT(ML),
    .FIFO_DEPTH(FD),
    .N_BFLY(N)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .stage(stage),
    .busy(busy),
    .done(done),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .mult_x(mult_x),
    .tw_addr(tw_addr),
    .mult_issue(mult_issue),
    .mult_result(mult_result),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_last(out_last),
    .out_ready(out_ready)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] din  [N];
  logic [63:0] prod [N];

  // multiplier stand-in and recorders
  logic        mv [0:ML];
  logic [63:0] md [0:ML];
  logic [4:0]  midx;
  int          cyc;
  int          ov_first;
  int          hold_bad;
  logic        prev_stall;
  logic        prev_busy;
  logic [31:0] prev_d;
  logic        prev_l;
  logic [31:0] iss_x [$];
  logic [4:0]  iss_tw [$];
  logic [31:0] out_d [$];
  logic        out_l [$];
  int          out_cyc [$];
  int          acc_q [$];
  int          done_q [$];
  int          busy_q [$];

  assign mult_result = mv[ML] ? md[ML]
                     : 64'hDEAD_BEEF_0BAD_F00D;

  initial begin
    cyc = 0;
    midx = '0;
    ov_first = -1;
    hold_bad = 0;
    prev_stall = 1'b0;
    prev_busy = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    for (int i = 0; i <= ML; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = ML; i > 0; i--) begin
        mv[i] = mv[i-1];
        md[i] = md[i-1];
      end
      mv[0] = 1'b0;
      md[0] = '0;
      if (!reset_n) begin
        prev_stall = 1'b0;
        prev_busy = 1'b0;
        continue;
      end
      if (start && !busy) begin
        iss_x.delete();
        iss_tw.delete();
        out_d.delete();
        out_l.delete();
        out_cyc.delete();
        acc_q.delete();
        done_q.delete();
        busy_q.delete();
        midx = '0;
        hold_bad = 0;
        ov_first = -1;
      end
      if (mult_issue) begin
        mv[0] = 1'b1;
        md[0] = prod[midx];
        midx++;
        iss_x.push_back(mult_x);
        iss_tw.push_back(tw_addr);
      end
      if (in_valid && in_ready)
        acc_q.push_back(cyc);
      if (out_valid && ov_first < 0)
        ov_first = cyc;
      if (prev_stall && (!out_valid
          || out_data !== prev_d
          || out_last !== prev_l))
        hold_bad++;
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_last;
      if (out_valid && out_ready) begin
        out_d.push_back(out_data);
        out_l.push_back(out_last);
        out_cyc.push_back(cyc);
      end
      if (done)
        done_q.push_back(cyc);
      if (prev_busy && !busy)
        busy_q.push_back(cyc);
      prev_busy = busy;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // floor((x + 2^14) / 2^15), clamped to int16
  function automatic logic [15:0] ref_round(
      input logic [31:0] x);
    longint v;
    longint q;
    v = longint'($signed(x)) + 64'sd16384;
    if (v >= 0)
      q = v / 32768;
    else
      q = -((-v + 32767) / 32768);
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  // exponent k of W64^k for butterfly j of stage st
  function automatic logic [4:0] ref_tw(
      input int st, input int j);
    int grp;
    grp = 32 >> st;
    return 5'(((j % grp) * (1 << st)) % 32);
  endfunction

  task automatic run_stage(input int st,
                           input int mode,
                           input bit dir,
                           input bit restart);
    for (int i = 0; i < N; i++) begin
      din[i]  = $urandom;
      prod[i] = {$urandom, $urandom};
    end
    if (dir) begin
      prod[0] = {32'h0000_4000, 32'h0000_3FFF};
      prod[1] = {32'hFFFF_C000, 32'hBFFF_0000};
      prod[2] = {32'h4000_0000, 32'h0000_0000};
    end
    out_ready = (mode != 2);
    @(posedge clk); #1;
    start = 1'b1;
    stage = 3'(st);
    @(posedge clk); #1;
    start = 1'b0;
    fork
      begin : drv
        int to;
        for (int i = 0; i < N; i++) begin
          in_valid = 1'b1;
          in_data  = din[i];
          to = 0;
          forever begin
            @(negedge clk);
            if (in_ready) break;
            to++;
            if (to > 300) break;
          end
          if (to > 300) begin
            chk("accept_timeout", in_ready, 1);
            break;
          end
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
      end
      begin : rdy
        if (mode == 2) begin
          repeat (20) @(posedge clk);
          #1;
          chk("bp_accepts", acc_q.size(), FD);
          chk("bp_in_ready", in_ready, 0);
        end
        if (restart) begin
          repeat (6) @(posedge clk);
          #1;
          start = 1'b1;
          stage = 3'd0;
          @(posedge clk); #1;
          start = 1'b0;
          chk("restart_busy", busy, 1);
        end
        for (int k = 0; k < 3000; k++) begin
          if (done_q.size() != 0) break;
          @(posedge clk); #1;
          out_ready = (mode == 1) ?
            ($urandom_range(0, 3) != 0) : 1'b1;
        end
        out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 2000; k++) begin
      if (done_q.size() != 0) break;
      @(posedge clk);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("done_count", done_q.size(), 1);
    chk("out_count", out_d.size(), N);
    chk("issue_count", iss_x.size(), N);
    chk("busy_end", busy, 0);
    chk("hold_stable", hold_bad, 0);
    for (int i = 0; i < N; i++) begin
      if (i < out_d.size()) begin
        chk($sformatf("s%0d_data[%0d]", st, i), out_d[i],
            {ref_round(prod[i][63:32]),
             ref_round(prod[i][31:0])});
        chk($sformatf("s%0d_last[%0d]", st, i), out_l[i],
            (i == N - 1));
      end
      if (i < iss_x.size()) begin
        chk($sformatf("s%0d_x[%0d]", st, i), iss_x[i],
            din[i]);
        chk($sformatf("s%0d_tw[%0d]", st, i), iss_tw[i],
            ref_tw(st, i));
      end
    end
    chk("first_latency",
        acc_q.size() > 0 ? ov_first - acc_q[0] : -1,
        1 + ML + 1);
    chk("done_cycle",
        (out_cyc.size() == N && done_q.size() > 0) ?
          done_q[0] - out_cyc[N-1] : -1,
        1);
    chk("busy_fall_cycle",
        (busy_q.size() > 0 && done_q.size() > 0) ?
          busy_q[0] - done_q[0] : -1,
        0);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    stage     = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      din[i]  = '0;
      prod[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_issue", mult_issue, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_mult_x", mult_x, 0);
    chk("rst_tw", tw_addr, 0);
    chk("rst_out_data", out_data, 0);
    reset_n = 1'b1;

    run_stage(0, 0, 1'b1, 1'b0);
    chk("round_a", out_d.size() > 0 ? out_d[0] : 'x,
        32'h0001_0000);
    chk("round_b", out_d.size() > 1 ? out_d[1] : 'x,
        32'h0000_8000);
    chk("sat_pos", out_d.size() > 2 ? out_d[2] : 'x,
        32'h7FFF_0000);

    run_stage(1, 1, 1'b0, 1'b0);
    chk("s1_b17", iss_tw.size() > 17 ? iss_tw[17] : 'x, 2);

    run_stage(5, 1, 1'b0, 1'b0);

    run_stage(3, 0, 1'b0, 1'b0);
    chk("s3_b13", iss_tw.size() > 13 ? iss_tw[13] : 'x, 8);

    run_stage(2, 2, 1'b0, 1'b0);

    @(posedge clk); #1;
    start = 1'b1;
    stage = 3'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bad_stage_busy", busy, 0);
    chk("bad_stage_in_ready", in_ready, 0);

    run_stage(4, 1, 1'b0, 1'b1);

    // reset with two products in flight
    for (int i = 0; i < N; i++) begin
      din[i]  = $urandom;
      prod[i] = {$urandom, $urandom};
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    stage = 3'd0;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_data = din[0];
    @(posedge clk); #1;
    in_data = din[1];
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = '0;
    chk("mid_accepts", acc_q.size(), 2);
    chk("mid_issue", mult_issue, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_issue", mult_issue, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_mult_x", mult_x, 0);
    chk("mid_rst_tw", tw_addr, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_stale_outputs", out_d.size(), 0);
    chk("no_stale_valid", out_valid, 0);

    run_stage(2, 1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/twiddle_mult_sched.md
Name: twiddle_mult_sched

Overview:
- Stage-level scheduler for the shared fixed-point complex multiplier in the 64-point radix-2 DIF FFT.
- Per stage, accepts 32 lower-leg butterfly outputs and issues each to the multiplier with its twiddle ROM address.
- Tracks in-flight products, then rounds and saturates the 64-bit products back to packed 16+16 samples.
- Buffers results in a small credit-controlled FIFO, so downstream backpressure never drops a product.

Parameters:
- MULT_LAT, 2, cycles from mult_issue high to mult_result valid (fixed pipeline, 0 not allowed).
- FIFO_DEPTH, 4, result buffer entries; also the credit limit (must be >= 1).
- N_BFLY, 32, butterflies per stage (N/2 for 64-point).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin a stage
- stage  in  3  stage number 0..5, sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last output handshake
- in_valid  in  1  butterfly lower-leg sample valid
- in_data  in  32  {re[31:16], im[15:0]} signed Q1.15
- in_ready  out  1  sample accepted when in_valid&in_ready
- mult_x  out  32  operand to multiplier (registered copy of in_data)
- tw_addr  out  5  twiddle ROM index, exponent k of W64^k... restricted to 0..31
- mult_issue  out  1  operand valid this cycle
- mult_result  in  64  {re[63:32], im[31:0]} signed Q2.30 product
- out_valid  out  1  FIFO head valid
- out_data  out  32  {re16, im16} rounded product
- out_last  out  1  marks the 32nd output of the stage
- out_ready  in  1  downstream accepts when out_valid&out_ready

Behaviour:
- Reset (async, reset_n=0): state IDLE. busy, done, in_ready, mult_issue, out_valid and out_last are 0. mult_x, tw_addr and out_data are 0. Counters, credits, FIFO and in-flight pipe are cleared. Reset mid-stage discards all in-flight products.
- FSM IDLE: start=1 with stage<=5 latches stage and goes to RUN, busy=1. start with stage>5 is ignored. start while not IDLE is ignored.
- FSM RUN: issue counter b runs 0..N_BFLY-1.
  - in_ready = (b<N_BFLY) && (credits>0), where credits = FIFO_DEPTH - fifo_count - inflight.
  - On accept, the next cycle shows mult_issue=1, mult_x=in_data and tw_addr=(b & ((32>>s)-1)) << s, truncated to 5 bits; then b increments.
  - After the 32nd accept, go to DRAIN.
- FSM DRAIN: wait until inflight=0, FIFO empty and all 32 outputs popped. Then go to DONE.
- FSM DONE: done=1 for one cycle, busy=0, then IDLE.
- inflight counts issues minus returns. A MULT_LAT-deep valid shift register tracks returns. A credit is consumed at accept and released on FIFO pop, so FIFO overflow is impossible by construction.
- Result capture: when the delayed issue valid is high, mult_result is sampled and written to the FIFO.
  - Per component x (32-bit signed): y = (x + 2^14) >>> 15 (arithmetic shift).
  - y is saturated to [-32768, 32767], then truncated to 16 bits.
  - out_last is stored with the entry and set on the 32nd capture.
- Simultaneous FIFO push and pop in one cycle is legal; the count is unchanged.
- Output holds stable while out_valid && !out_ready.
- Throughput: 1 sample/clock when out_ready stays high. First out_valid appears 1+MULT_LAT+1 cycles after the first accept.

Test Plan:
- Stage 0, out_ready=1, 32 back-to-back samples -> tw_addr sequence 0,1,...,31. done pulses exactly once, 1 cycle after the 32nd output. busy falls the same cycle.
- Stage 1, b=17 -> tw_addr=2. Stage 5 -> all tw_addr=0. Stage 3, b=13 -> tw_addr=(13&3)<<3=8.
- Rounding: re=0x00004000 -> re16=0x0001. re=0x00003FFF -> 0x0000. re=0xFFFFC000 -> 0x0000. Saturation: re=0x40000000 -> 0x7FFF; im=0xBFFF0000 -> 0x8000.
- Backpressure: out_ready=0 from start, FIFO_DEPTH=4 -> exactly 4 samples accepted, then in_ready stays 0. Raising out_ready resumes; all 32 outputs arrive in order, with out_last only on the 32nd.
- Start handling: start with stage=6 -> busy stays 0. A second start mid-RUN -> ignored, stage unchanged.
- Reset: assert reset_n=0 mid-RUN with 2 in flight -> all outputs 0 immediately, no stale out_valid after release. A new stage then completes normally.
